// File: rtl/aes_inv_sbox_seq.sv
// Sequential AES inverse S-box: inverse affine on the input byte, then a^254
// computed over seven square-and-multiply steps, behind valid/ready handshakes.
module aes_inv_sbox_seq #(
  parameter logic [7:0] AFF_CONST = 8'h05,
  parameter logic [7:0] GF_POLY   = 8'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       busy
);

  // Handshakes: a byte moves on any rising edge where valid && ready are both
  // high; valid never waits on ready, and ready never depends on valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] s, r, data_q;
  logic [2:0] cnt;
  logic [7:0] b, s_sq, r_mul;

  // Shift-and-add multiply; each doubling folds x^8 back in via GF_POLY.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  always_comb begin
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = data_in[(i + 2) % 8] ^ data_in[(i + 5) % 8] ^ data_in[(i + 7) % 8] ^ AFF_CONST[i];
    end
  end

  assign s_sq  = gf_mul(s, s);
  assign r_mul = gf_mul(r, s_sq);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (cnt == 3'd6) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s      <= 8'h00;
      r      <= 8'h00;
      cnt    <= 3'd0;
      data_q <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            s   <= b;
            r   <= 8'h01;
            cnt <= 3'd0;
          end
        end
        CALC: begin
          // After k steps s = b^(2^k) and r = b^(2+4+...+2^k); step 7 gives b^254.
          s   <= s_sq;
          r   <= r_mul;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) data_q <= r_mul;
        end
        default: ;
      endcase
    end
  end

  // Held low during reset even though the state register already reads IDLE.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// Directed and exhaustive bench for aes_inv_sbox_seq, checked against an
// independently built forward S-box (brute-force inverse plus forward affine).
module tb_aes_inv_sbox_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] inv_tab [256];
  logic [7:0] exp_q [$];

  aes_inv_sbox_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] m);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (m[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // ---------------- driver ----------------
  // Sends one byte, waits for out_valid, captures the result, then pops it.
  task automatic run_byte(input logic [7:0] d, output logic [7:0] res, output int lat,
                          output logic busy_ok);
    int guard;
    res     = 8'h00;
    lat     = 0;
    busy_ok = 1'b1;
    guard   = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = 8'hA5;
    while (!out_valid && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    if (!busy) busy_ok = 1'b0;
    res = data_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] res;
  int         lat;
  logic       bok;
  logic [7:0] got [$];
  logic       seen [256];
  int         distinct;

  initial begin
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out",  32'(data_out),  32'h00);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 0x63 maps through b==0, the zero-inverse corner
    run_byte(8'h63, res, lat, bok);
    check("inv_63", 32'(res), 32'h00);
    check("latency_63", 32'(lat), 32'd7);
    check("busy_63", 32'(bok), 32'd1);
    check("idle_after_pop", 32'(in_ready), 32'd1);
    check("ov_after_pop", 32'(out_valid), 32'd0);

    run_byte(8'h00, res, lat, bok); check("inv_00", 32'(res), 32'h52);
    run_byte(8'h01, res, lat, bok); check("inv_01", 32'(res), 32'h09);
    run_byte(8'hFF, res, lat, bok); check("inv_ff", 32'(res), 32'h7D);
    run_byte(8'hED, res, lat, bok); check("inv_ed", 32'(res), 32'h53);

    // Backpressure: result must hold while out_ready stays low
    in_valid = 1'b1; data_in = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i % 5 == 0) begin
        check("bp_hold_data", 32'(data_out), 32'h09);
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high
    begin
      int acc_cyc [$];
      exp_q = {8'h01, 8'h6A};
      got.delete();
      in_valid = 1'b1; data_in = 8'h7C; out_ready = 1'b1;
      for (int c = 0; c < 40 && got.size() < 2; c++) begin
        logic accepted;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted) acc_cyc.push_back(c);
        if (out_valid) got.push_back(data_out);
        @(posedge clk); #1;
        if (accepted && acc_cyc.size() == 1) data_in = 8'h02;
        if (accepted && acc_cyc.size() == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b_out_count", 32'(got.size()), 32'd2);
      check("b2b_acc_count", 32'(acc_cyc.size()), 32'd2);
      if (acc_cyc.size() == 2) check("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
      while (got.size() > 0 && exp_q.size() > 0)
        check("b2b_data", 32'(got.pop_front()), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;

    // Reset while in CALC with cnt==3
    in_valid = 1'b1; data_in = 8'h63;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_data_out", 32'(data_out), 32'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      logic rose;
      rose = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk); #1;
        if (out_valid) rose = 1'b1;
      end
      check("abort_no_result", 32'(rose), 32'd0);
    end
    run_byte(8'h63, res, lat, bok);
    check("after_abort_63", 32'(res), 32'h00);

    // Exhaustive sweep against the reference table
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int y = 0; y < 256; y++) begin
      run_byte(8'(y), res, lat, bok);
      check($sformatf("sweep_%02h", y), 32'(res), 32'(inv_tab[y]));
      if (!seen[res]) begin
        seen[res] = 1'b1;
        distinct++;
      end
    end
    check("sweep_distinct", 32'(distinct), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
